// File: rtl/note_div_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// note_div_scheduler_pkg
//   Shared music-block package: scheduler FSM state enum, channel select type,
//   divider geometry (27-bit dividend, 27 quotient cycles, 33-bit divisor)
//   and the all-ones saturate value used for out-of-range / divide-by-zero.
// -----------------------------------------------------------------------------
package note_div_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_STORE  = 2'd3
    } div_state_e;

    typedef enum logic {
        CH_L = 1'b0,
        CH_R = 1'b1
    } chan_e;

    // CLK_HZ is taken as a 27-bit dividend, producing one quotient bit per cycle.
    localparam int DIVIDEND_W = 27;
    localparam int DIV_CYCLES = 27;
    // Octave-up doubles a 32-bit frequency, so the divisor needs one extra bit.
    localparam int DIVISOR_W  = 33;

    // Truncated to DIV_W at the point of use; DIV_W may be at most 64.
    localparam logic [63:0] DIV_SAT_ONES = '1;

endpackage

// File: rtl/note_div_scheduler_serial_divider.sv
// -----------------------------------------------------------------------------
// serial_divider
//   Restoring divider: constant dividend CLK_HZ (27 bits) / divisor_i (33 bits),
//   one quotient bit per cycle, MSB first.
//
//   Handshake: start_i is a one-cycle strobe that captures divisor_i and
//   restarts the division (it wins over a division in flight). The next 27
//   cycles each retire one quotient bit; done_o is high during the cycle that
//   retires the last bit, and quotient_o is valid from the following cycle
//   until the next start_i. A zero divisor yields an all-ones quotient.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   start_i      : start strobe
//   divisor_i    : divisor, sampled with start_i
//   done_o       : high during the final quotient step
//   quotient_o   : 27-bit quotient
// -----------------------------------------------------------------------------
module serial_divider
    import note_div_scheduler_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  done_o,
    output logic [DIVIDEND_W-1:0] quotient_o
);

    // Partial remainder stays below the divisor, so 33 bits hold it; the
    // extra bit keeps the shifted trial value and subtraction at one width.
    logic [DIVISOR_W:0]    rem_q, rem_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [DIVISOR_W:0]    rem_sh;
    logic [DIVISOR_W:0]    rem_sub;
    logic                  unused_rem_msb;

    always_comb begin
        // The quotient register doubles as the dividend shifter: its MSB
        // feeds the remainder while new quotient bits enter at the LSB.
        rem_sh  = {rem_q[DIVISOR_W-1:0], quo_q[DIVIDEND_W-1]};
        rem_sub = rem_sh - {1'b0, dvs_q};
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        if (start_i) begin
            rem_d = '0;
            quo_d = DIVIDEND_W'(CLK_HZ);
            dvs_d = divisor_i;
            cnt_d = 5'(DIV_CYCLES);
        end else if (cnt_q != 5'd0) begin
            if (rem_sh >= {1'b0, dvs_q}) begin
                rem_d = rem_sub;
                quo_d = {quo_q[DIVIDEND_W-2:0], 1'b1};
            end else begin
                rem_d = rem_sh;
                quo_d = {quo_q[DIVIDEND_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign done_o         = (cnt_q == 5'd1) && !start_i;
    assign quotient_o     = quo_q;
    assign unused_rem_msb = rem_q[DIVISOR_W];

endmodule

// File: rtl/note_div_scheduler.sv
// -----------------------------------------------------------------------------
// note_div_scheduler
//   Computes the left/right note dividers CLK_HZ / freq with a single shared
//   serial divider, time-multiplexed between the channels. A channel requests
//   service while its effective divisor differs from the divisor it last
//   captured; simultaneous requests are granted round-robin.
//   FSM: IDLE -> LOAD (1 cycle) -> DIVIDE (27 cycles) -> STORE (1 cycle).
//   The done pulse and the new divider value appear 29 cycles after LOAD entry.
//
//   Build option: NOTE_DIV_OCTAVE_EN
//     defined   : octave 1 halves the divisor, 3 doubles it, others nominal
//     undefined : divisor is the zero-extended frequency, octave is ignored
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   freq_l, freq_r   : raw tone frequencies (32 bits)
//   octave           : octave select (3 bits)
//   div_l, div_r     : registered dividers (DIV_W bits), all ones on reset,
//                      saturated to all ones on overflow / zero divisor
//   done_l, done_r   : one-cycle pulse when div_l / div_r is written
//   busy             : FSM not in IDLE
//   dbg_state_o      : current FSM state
// -----------------------------------------------------------------------------
module note_div_scheduler
    import note_div_scheduler_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int          DIV_W  = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      freq_l,
    input  logic [31:0]      freq_r,
    input  logic [2:0]       octave,
    output logic [DIV_W-1:0] div_l,
    output logic [DIV_W-1:0] div_r,
    output logic             done_l,
    output logic             done_r,
    output logic             busy,
    output div_state_e       dbg_state_o
);

    localparam logic [63:0] SAT_LIMIT = DIV_SAT_ONES >> (64 - DIV_W);

    div_state_e             state_q, state_d;
    chan_e                  last_q, last_d;
    logic [DIVISOR_W-1:0]   eff_l, eff_r;
    logic [DIVISOR_W-1:0]   cap_l_q, cap_r_q;
    logic [DIV_W-1:0]       div_l_q, div_r_q;
    logic                   done_l_q, done_r_q;
    logic                   pend_l, pend_r, pend_any;
    chan_e                  pick;
    logic                   start_div, load_l, load_r, store_l, store_r;
    logic [DIVISOR_W-1:0]   div_operand;
    logic                   div_done;
    logic [DIVIDEND_W-1:0]  quotient;
    logic [DIVISOR_W-1:0]   sel_cap;
    logic [DIV_W-1:0]       result;

`ifdef NOTE_DIV_OCTAVE_EN
    always_comb begin
        eff_l = {1'b0, freq_l};
        eff_r = {1'b0, freq_r};
        case (octave)
            3'd1: begin
                eff_l = {2'b00, freq_l[31:1]};
                eff_r = {2'b00, freq_r[31:1]};
            end
            3'd3: begin
                eff_l = {freq_l, 1'b0};
                eff_r = {freq_r, 1'b0};
            end
            default: ;
        endcase
    end
`else
    logic unused_octave;
    assign eff_l         = {1'b0, freq_l};
    assign eff_r         = {1'b0, freq_r};
    assign unused_octave = ^octave;
`endif

    assign pend_l   = (eff_l != cap_l_q);
    assign pend_r   = (eff_r != cap_r_q);
    assign pend_any = pend_l | pend_r;

    // Round-robin: with both pending, serve the channel not served last.
    always_comb begin
        if (pend_l && pend_r) begin
            pick = (last_q == CH_L) ? CH_R : CH_L;
        end else if (pend_r) begin
            pick = CH_R;
        end else begin
            pick = CH_L;
        end
    end

    // State register; last_q always names the channel being served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= CH_R;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_any) begin
                    state_d = ST_LOAD;
                    last_d  = pick;
                end
            end
            ST_LOAD:   state_d = ST_DIVIDE;
            ST_DIVIDE: begin
                if (div_done) begin
                    state_d = ST_STORE;
                end
            end
            ST_STORE: begin
                if (pend_any) begin
                    state_d = ST_LOAD;
                    last_d  = pick;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        start_div = 1'b0;
        load_l    = 1'b0;
        load_r    = 1'b0;
        store_l   = 1'b0;
        store_r   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                start_div = 1'b1;
                load_l    = (last_q == CH_L);
                load_r    = (last_q == CH_R);
            end
            ST_STORE: begin
                store_l = (last_q == CH_L);
                store_r = (last_q == CH_R);
            end
            default: ;
        endcase
    end

    // Captured divisor and divider operand are the same snapshot.
    assign div_operand = (last_q == CH_L) ? eff_l : eff_r;

    serial_divider #(
        .CLK_HZ (CLK_HZ)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_div),
        .divisor_i  (div_operand),
        .done_o     (div_done),
        .quotient_o (quotient)
    );

    assign sel_cap = (last_q == CH_L) ? cap_l_q : cap_r_q;

    always_comb begin
        if ((sel_cap == '0) || (64'(quotient) > SAT_LIMIT)) begin
            result = DIV_W'(DIV_SAT_ONES);
        end else begin
            result = DIV_W'(quotient);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_l_q  <= '0;
            cap_r_q  <= '0;
            div_l_q  <= DIV_W'(DIV_SAT_ONES);
            div_r_q  <= DIV_W'(DIV_SAT_ONES);
            done_l_q <= 1'b0;
            done_r_q <= 1'b0;
        end else begin
            done_l_q <= store_l;
            done_r_q <= store_r;
            if (load_l) begin
                cap_l_q <= eff_l;
            end
            if (load_r) begin
                cap_r_q <= eff_r;
            end
            if (store_l) begin
                div_l_q <= result;
            end
            if (store_r) begin
                div_r_q <= result;
            end
        end
    end

    assign div_l       = div_l_q;
    assign div_r       = div_r_q;
    assign done_l      = done_l_q;
    assign done_r      = done_r_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_note_div_scheduler.sv
`timescale 1ns/1ps
module tb_note_div_scheduler;
    import note_div_scheduler_pkg::*;

    localparam int unsigned CLK_HZ   = 100_000_000;
    localparam int          DIV_W    = 22;
    localparam logic [21:0] ALL_ONES = 22'h3FFFFF;

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        rst_n;
    logic [31:0] freq_l, freq_r;
    logic [2:0]  octave;
    logic [21:0] div_l, div_r;
    logic        done_l, done_r, busy;
    div_state_e  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    note_div_scheduler #(
        .CLK_HZ (CLK_HZ),
        .DIV_W  (DIV_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .freq_l      (freq_l),
        .freq_r      (freq_r),
        .octave      (octave),
        .div_l       (div_l),
        .div_r       (div_r),
        .done_l      (done_l),
        .done_r      (done_r),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [21:0] exp_l_q[$];
    logic [21:0] exp_r_q[$];
    logic [21:0] held_l, held_r;
    longint      model_cap_l, model_cap_r;
    bit          model_last_r;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, got, exp);
    endtask

    function automatic longint eff_of(input longint f, input int oc);
        longint e;
        e = f;
`ifdef NOTE_DIV_OCTAVE_EN
        if (oc == 1) e = f / 2;
        else if (oc == 3) e = f * 2;
`else
        if (oc < 0) e = 0;
`endif
        return e;
    endfunction

    function automatic logic [21:0] expect_div(input longint eff);
        longint q;
        if (eff == 0) return ALL_ONES;
        q = longint'(CLK_HZ) / eff;
        if (q > 64'h3FFFFF) return ALL_ONES;
        return q[21:0];
    endfunction

    // Drive inputs and push the result each changed channel must produce.
    task automatic set_inputs(input logic [31:0] fl, input logic [31:0] fr, input logic [2:0] oc);
        longint el, er;
        bit     ch_l, ch_r;
        freq_l = fl;
        freq_r = fr;
        octave = oc;
        el   = eff_of(longint'(fl), int'(oc));
        er   = eff_of(longint'(fr), int'(oc));
        ch_l = (el != model_cap_l);
        ch_r = (er != model_cap_r);
        if (ch_l) exp_l_q.push_back(expect_div(el));
        if (ch_r) exp_r_q.push_back(expect_div(er));
        if (ch_l && !ch_r) model_last_r = 1'b0;
        else if (ch_r && !ch_l) model_last_r = 1'b1;
        model_cap_l = el;
        model_cap_r = er;
    endtask

    task automatic reset_model();
        exp_l_q.delete();
        exp_r_q.delete();
        model_cap_l  = 0;
        model_cap_r  = 0;
        model_last_r = 1'b1;
        held_l       = ALL_ONES;
        held_r       = ALL_ONES;
    endtask

    // ---------------- driver / wait tasks ----------------
    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        #1;
        check({name, " returns idle"}, busy, 0);
        check({name, " results drained"}, exp_l_q.size() + exp_r_q.size(), 0);
    endtask

    task automatic wait_busy(input string name, output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 100);
        check({name, " load entered"}, busy, 1);
        t = cyc;
    endtask

    task automatic wait_any_done(input string name, output bit ch, output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(done_l || done_r) && n < 200);
        check({name, " done seen"}, done_l | done_r, 1);
        ch = done_l ? 1'b0 : 1'b1;
        t  = cyc;
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [21:0] mon_exp;
    always @(negedge clk) begin
        if (rst_n) begin
            if (done_l) begin
                if (exp_l_q.size() == 0) begin
                    check("spurious done_l", done_l, 0);
                end else begin
                    mon_exp = exp_l_q.pop_front();
                    check("div_l value", div_l, mon_exp);
                    held_l = mon_exp;
                end
                check("div_r held during L store", div_r, held_r);
            end
            if (done_r) begin
                if (exp_r_q.size() == 0) begin
                    check("spurious done_r", done_r, 0);
                end else begin
                    mon_exp = exp_r_q.pop_front();
                    check("div_r value", div_r, mon_exp);
                    held_r = mon_exp;
                end
                check("div_l held during R store", div_l, held_l);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int          t0, t1;
        bit          ca, cb;
        bit          first_r;
        int          any_done;
        logic [31:0] rl, rr;
        logic [2:0]  ro;

        rst_n  = 1'b0;
        freq_l = '0;
        freq_r = '0;
        octave = 3'd2;
        reset_model();
        repeat (3) @(negedge clk);
        check("reset div_l", div_l, ALL_ONES);
        check("reset div_r", div_r, ALL_ONES);
        check("reset done_l", done_l, 0);
        check("reset done_r", done_r, 0);
        check("reset busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: 440 Hz on L, 29-cycle latency from LOAD
        set_inputs(32'd440, 32'd0, 3'd2);
        wait_busy("t1", t0);
        wait_any_done("t1", ca, t1);
        check("t1 channel is L", ca, 0);
        check("t1 latency", t1 - t0, 29);
        wait_idle("t1");
        check("t1 div_l", div_l, 227272);

        // Test 2: 262 Hz on R, octave up
        set_inputs(32'd440, 32'd262, 3'd3);
        wait_idle("t2");
`ifdef NOTE_DIV_OCTAVE_EN
        check("t2 div_r", div_r, 190839);
`else
        check("t2 div_r", div_r, 381679);
`endif

        // Test 3: both change in the same cycle, round-robin order
        first_r = !model_last_r;
        set_inputs(32'd500, 32'd300, 3'd3);
        wait_any_done("t3 first", ca, t0);
        wait_any_done("t3 second", cb, t1);
        check("t3 first channel", ca, first_r);
        check("t3 second channel", cb, !first_r);
        check("t3 done spacing", t1 - t0, 29);
        wait_idle("t3");

        // Test 4: saturation for freq 1 and freq 0
        set_inputs(32'd1, 32'd300, 3'd3);
        wait_idle("t4a");
        check("t4 div_l freq 1", div_l, ALL_ONES);
        set_inputs(32'd0, 32'd300, 3'd3);
        wait_idle("t4b");
        check("t4 div_l freq 0", div_l, ALL_ONES);
        set_inputs(32'd0, 32'd300, 3'd2);
        wait_idle("t4c");

        // Test 5: L changes 440->494 at DIVIDE cycle 10
        set_inputs(32'd440, 32'd300, 3'd2);
        wait_busy("t5", t0);
        repeat (10) @(negedge clk);
        set_inputs(32'd494, 32'd300, 3'd2);
        wait_any_done("t5 first", ca, t0);
        check("t5 first channel", ca, 0);
        check("t5 first div_l", div_l, 227272);
        wait_any_done("t5 second", cb, t1);
        check("t5 second channel", cb, 0);
        check("t5 second div_l", div_l, 202429);
        check("t5 back-to-back spacing", t1 - t0, 29);
        wait_idle("t5");

        // Test 6: reset mid-DIVIDE
        set_inputs(32'd494, 32'd1000, 3'd2);
        wait_busy("t6", t0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6 div_l in reset", div_l, ALL_ONES);
        check("t6 div_r in reset", div_r, ALL_ONES);
        check("t6 busy in reset", busy, 0);
        check("t6 done_l in reset", done_l, 0);
        check("t6 done_r in reset", done_r, 0);
        reset_model();
        any_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_l || done_r) any_done++;
        end
        check("t6 no done while in reset", any_done, 0);
        rst_n = 1'b1;
        set_inputs(32'd494, 32'd1000, 3'd2);
        wait_idle("t6 rerequest");
        check("t6 div_l after rerequest", div_l, 202429);
        check("t6 div_r after rerequest", div_r, 100000);

        // Randomized phase
        for (int i = 0; i < 12; i++) begin
            rl = freq_l;
            rr = freq_r;
            ro = octave;
            case ($urandom_range(0, 3))
                0: rl = $urandom_range(0, 30000);
                1: rr = $urandom_range(0, 30000);
                2: begin
                    rl = $urandom_range(1, 30000);
                    rr = $urandom_range(1, 30000);
                end
                default: begin
                    rl = $urandom_range(1, 5000);
                    rr = $urandom_range(1, 5000);
                    ro = 3'($urandom_range(0, 7));
                end
            endcase
            set_inputs(rl, rr, ro);
            wait_idle("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/note_div_scheduler.md
NOTE_DIV_SCHEDULER -- requirements
Module: note_div_scheduler

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, SHALL be the constant dividend for every division.
REQ-002 Parameter DIV_W, default 22, SHALL be the width of each divider result.
REQ-003 Port clk, input, 1: single system clock; all logic SHALL be on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port freq_l, input, 32: raw left-channel tone frequency from the music module.
REQ-006 Port freq_r, input, 32: raw right-channel tone frequency.
REQ-007 Port octave, input, 3: octave select; 1 = down, 2 = nominal, 3 = up, others = nominal.
REQ-008 Port div_l, output, DIV_W: registered left note divider, consumed by note_gen.
REQ-009 Port div_r, output, DIV_W: registered right note divider.
REQ-010 Port done_l / done_r, output, 1 each: one-cycle pulse when div_l / div_r updates.
REQ-011 Port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-012 The block SHALL replace per-channel combinational dividers with one shared serial restoring divider, time-multiplexed between L and R.
REQ-013 Effective divisor per channel SHALL be 33 bits: freq>>1 if octave==1; freq<<1 if octave==3; freq otherwise.
REQ-014 Each channel SHALL hold a captured divisor; a request for that channel SHALL be pending while its effective divisor differs from its captured divisor.
REQ-015 FSM states SHALL be IDLE, LOAD, DIVIDE, STORE.
REQ-016 IDLE -> LOAD when any request is pending; with both pending, grant SHALL go to the channel not granted last (round-robin).
REQ-017 LOAD (1 cycle) SHALL snapshot the granted channel's effective divisor into the captured register and the divider operand.
REQ-018 DIVIDE SHALL run exactly 27 cycles, one quotient bit per cycle, MSB first; the dividend is CLK_HZ in 27 bits.
REQ-019 STORE (1 cycle) SHALL write the result to div_l or div_r, pulse the matching done, then go to LOAD if a request is pending, else IDLE.
REQ-020 Latency from LOAD entry to done pulse SHALL be 29 cycles.
REQ-021 If the quotient exceeds 2^DIV_W-1 or the divisor is zero, the result SHALL saturate to all ones.
REQ-022 An input change during DIVIDE SHALL NOT disturb the running division; it SHALL raise a new request, serviced per REQ-016.
REQ-023 div_l/div_r SHALL hold their value between STOREs; the uncomputed channel is never glitched.

Reset
REQ-024 On rst_n low: state IDLE, div_l = div_r = all ones, done_l = done_r = 0, busy = 0, captured divisors = 0, last grant = R.
REQ-025 Reset mid-division SHALL abort the division with no STORE; after release, nonzero inputs re-request.

Configuration
REQ-026 With NOTE_DIV_OCTAVE_EN defined, REQ-013 octave scaling SHALL apply; without it, the effective divisor SHALL be zero-extended freq and octave SHALL be ignored.

Structure
REQ-027 The FSM state enum, the 27-cycle count constant and the saturate value SHALL live in the shared music package.
REQ-028 The serial divider SHALL be the sub-module serial_divider (start/done handshake); arbitration and FSM stay in note_div_scheduler.

Verification
REQ-029 Test 1: reset release, freq_l=440, octave=2. Required: done_l 29 cycles after LOAD; div_l=227272.
REQ-030 Test 2: freq_r=262, octave=3. Required: div_r=190839; with the macro undefined, div_r=381679.
REQ-031 Test 3: freq_l and freq_r change in the same cycle. Required: L serviced first; done_r exactly 29 cycles after done_l.
REQ-032 Test 4: freq_l=1 or freq_l=0. Required: div_l=22'h3FFFFF.
REQ-033 Test 5: freq_l changes 440->494 at DIVIDE cycle 10. Required: div_l=227272, then div_l=202429 on the following STORE.
REQ-034 Test 6: rst_n asserted mid-DIVIDE. Required: outputs immediately all ones, busy=0, no done pulse.
